// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for serial_subtractor.
// Ovf is present only when SERIAL_SUB_SIGNED_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             Bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             Ovf;
`endif

  modport master (
    output start,
    output A,
    output B,
    input  busy,
    input  done,
    input  Result,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    input  Ovf,
`endif
    input  Bout
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    output busy,
    output done,
    output Result,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    output Ovf,
`endif
    output Bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell and a registered borrow.
// Define SERIAL_SUB_SIGNED_OVF_EN to add the signed-overflow output Ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave sub_if
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CntW-1:0]  r_cnt;
  logic             r_bor;
  logic [WIDTH-1:0] r_result;
  logic             r_bout;
  logic             w_d;
  logic             w_bor_next;

  assign w_d        = r_a[0] ^ r_b[0] ^ r_bor;
  assign w_bor_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bor);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (sub_if.start) begin
          w_state_next = StRun;
          w_accept     = 1'b1;
        end
      end
      StRun: begin
        if (r_cnt == LastCnt) begin
          w_state_next = StDone;
          w_last       = 1'b1;
        end
      end
      StDone: begin
        if (sub_if.start) begin
          w_state_next = StRun;
          w_accept     = 1'b1;
        end else begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_bor    <= 1'b0;
      r_result <= '0;
      r_bout   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a    <= sub_if.A;
        r_b    <= sub_if.B;
        r_diff <= '0;
        r_cnt  <= '0;
        r_bor  <= 1'b0;
      end else if (r_state == StRun) begin
        r_a    <= r_a >> 1;
        r_b    <= r_b >> 1;
        r_diff <= {w_d, r_diff[WIDTH-1:1]};
        r_bor  <= w_bor_next;
        r_cnt  <= r_cnt + CntW'(1);
      end
      // Last RUN cycle: the final difference bit is still on w_d, not yet in r_diff.
      if (w_last) begin
        r_result <= {w_d, r_diff[WIDTH-1:1]};
        r_bout   <= w_bor_next;
      end
    end
  end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic r_sa;
  logic r_sb;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sa <= sub_if.A[WIDTH-1];
        r_sb <= sub_if.B[WIDTH-1];
      end
      if (w_last) begin
        r_ovf <= (r_sa != r_sb) && (w_d != r_sa);
      end
    end
  end

  assign sub_if.Ovf = r_ovf;
`endif

  assign sub_if.busy   = (r_state == StRun);
  assign sub_if.done   = (r_state == StDone);
  assign sub_if.Result = r_result;
  assign sub_if.Bout   = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4), plus a full operand sweep.
// Ovf checks are active when SERIAL_SUB_SIGNED_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  serial_subtractor_if #(.WIDTH(W)) sub_if ();

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .sub_if (sub_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    check_eq(tag, 32'(sub_if.Ovf), 32'(exp));
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one subtraction and checks every cycle until the done pulse has passed.
  // Result/Bout must hold prev_* throughout RUN.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic scramble, input logic [3:0] prev_res,
                        input logic prev_bout, input logic [3:0] exp_res,
                        input logic exp_bout, input logic exp_ovf);
    sub_if.start = 1'b1;
    sub_if.A     = a;
    sub_if.B     = b;
    tick();
    sub_if.start = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      check_eq({tag, " busy"}, 32'(sub_if.busy), 32'd1);
      check_eq({tag, " no done"}, 32'(sub_if.done), 32'd0);
      check_eq({tag, " hold res"}, 32'(sub_if.Result), 32'(prev_res));
      check_eq({tag, " hold bout"}, 32'(sub_if.Bout), 32'(prev_bout));
      if (scramble) begin
        sub_if.start = 1'($urandom_range(1, 0));
        sub_if.A     = 4'($urandom);
        sub_if.B     = 4'($urandom);
      end
      tick();
    end
    check_eq({tag, " done"}, 32'(sub_if.done), 32'd1);
    check_eq({tag, " busy end"}, 32'(sub_if.busy), 32'd0);
    check_eq({tag, " result"}, 32'(sub_if.Result), 32'(exp_res));
    check_eq({tag, " bout"}, 32'(sub_if.Bout), 32'(exp_bout));
    check_ovf({tag, " ovf"}, exp_ovf);
    sub_if.start = 1'b0;
    tick();
    check_eq({tag, " done pulse"}, 32'(sub_if.done), 32'd0);
    check_eq({tag, " idle"}, 32'(sub_if.busy), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_r;
    logic       exp_b;
    logic       exp_o;
    logic [3:0] last_r;
    logic       last_b;
    n_total      = 0;
    n_bad        = 0;
    rst          = 1'b1;
    sub_if.start = 1'b0;
    sub_if.A     = '0;
    sub_if.B     = '0;
    tick();
    tick();
    check_eq("rst busy", 32'(sub_if.busy), 32'd0);
    check_eq("rst done", 32'(sub_if.done), 32'd0);
    check_eq("rst result", 32'(sub_if.Result), 32'd0);
    check_eq("rst bout", 32'(sub_if.Bout), 32'd0);
    check_ovf("rst ovf", 1'b0);
    rst = 1'b0;
    tick();
    check_eq("idle busy", 32'(sub_if.busy), 32'd0);

    run_op("5-3", 4'd5, 4'd3, 1'b0, 4'd0, 1'b0, 4'd2, 1'b0, 1'b0);
    run_op("3-5", 4'd3, 4'd5, 1'b0, 4'd2, 1'b0, 4'hE, 1'b1, 1'b0);
    run_op("0-1", 4'd0, 4'd1, 1'b0, 4'hE, 1'b1, 4'hF, 1'b1, 1'b0);
    run_op("9-9", 4'd9, 4'd9, 1'b0, 4'hF, 1'b1, 4'd0, 1'b0, 1'b0);

    // Back-to-back: start held high; operands swapped during RUN of the first op.
    sub_if.start = 1'b1;
    sub_if.A     = 4'd12;
    sub_if.B     = 4'd4;
    tick();
    sub_if.A = 4'd1;
    sub_if.B = 4'd2;
    for (int i = 0; i < int'(W); i++) begin
      check_eq("b2b busy1", 32'(sub_if.busy), 32'd1);
      check_eq("b2b nodone1", 32'(sub_if.done), 32'd0);
      tick();
    end
    check_eq("b2b done1", 32'(sub_if.done), 32'd1);
    check_eq("b2b res1", 32'(sub_if.Result), 32'd8);
    check_eq("b2b bout1", 32'(sub_if.Bout), 32'd0);
    tick();
    sub_if.start = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      check_eq("b2b busy2", 32'(sub_if.busy), 32'd1);
      check_eq("b2b nodone2", 32'(sub_if.done), 32'd0);
      check_eq("b2b hold", 32'(sub_if.Result), 32'd8);
      tick();
    end
    check_eq("b2b done2", 32'(sub_if.done), 32'd1);
    check_eq("b2b res2", 32'(sub_if.Result), 32'hF);
    check_eq("b2b bout2", 32'(sub_if.Bout), 32'd1);
    tick();
    check_eq("b2b idle", 32'(sub_if.done), 32'd0);

    // Operands and start toggled every RUN cycle must not disturb the op in flight.
    run_op("10-6 scr", 4'd10, 4'd6, 1'b1, 4'hF, 1'b1, 4'd4, 1'b0, 1'b1);

    // Abort mid-RUN.
    sub_if.start = 1'b1;
    sub_if.A     = 4'd7;
    sub_if.B     = 4'd1;
    tick();
    sub_if.start = 1'b0;
    tick();
    check_eq("abort busy pre", 32'(sub_if.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort busy", 32'(sub_if.busy), 32'd0);
    check_eq("abort result", 32'(sub_if.Result), 32'd0);
    check_eq("abort bout", 32'(sub_if.Bout), 32'd0);
    check_ovf("abort ovf", 1'b0);
    for (int i = 0; i < 8; i++) begin
      check_eq("abort no done", 32'(sub_if.done), 32'd0);
      tick();
    end
    run_op("5-3 again", 4'd5, 4'd3, 1'b0, 4'd0, 1'b0, 4'd2, 1'b0, 1'b0);

    run_op("8-1", 4'd8, 4'd1, 1'b0, 4'd2, 1'b0, 4'd7, 1'b0, 1'b1);
    run_op("7-15", 4'd7, 4'd15, 1'b0, 4'd7, 1'b0, 4'd8, 1'b1, 1'b1);
    run_op("2-3", 4'd2, 4'd3, 1'b0, 4'd8, 1'b1, 4'hF, 1'b1, 1'b0);

    last_r = 4'hF;
    last_b = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        exp_r = 4'(a - b);
        exp_b = (a < b);
        exp_o = (a[3] != b[3]) && (exp_r[3] != a[3]);
        run_op($sformatf("sweep %0d-%0d", a, b), 4'(a), 4'(b), 1'b0, last_r, last_b,
               exp_r, exp_b, exp_o);
        last_r = exp_r;
        last_b = exp_b;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial multi-cycle subtractor computing Result = A - B, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a registered borrow.
- This is the subtract direction of the team's ripple adder. It trades latency for area in the datapath and is driven by a control FSM through a start/done handshake.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; operands sampled on the same edge when accepted
- A  input  WIDTH  minuend
- B  input  WIDTH  subtrahend
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse; Result and Bout are valid from this cycle on
- Result  output  WIDTH  difference A - B, modulo 2^WIDTH
- Bout  output  1  borrow out; 1 iff A < B unsigned

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst; rst takes priority over every other input.
- Reset values: busy=0, done=0, Result=0, Bout=0. FSM goes to IDLE; internal shift registers, bit counter and borrow are all cleared.
- FSM states:
  - IDLE: start=1 latches A and B into shift registers, clears borrow and counter, goes to RUN. start=0 stays in IDLE.
  - RUN: each cycle processes operand bit i = counter.
    - d = a_i ^ b_i ^ bor
    - bor_next = (~a_i & b_i) | (~(a_i ^ b_i) & bor)
    - d is shifted into the MSB of the internal difference register; the operand registers shift right.
    - After WIDTH RUN cycles (counter == WIDTH-1), the completed difference is copied to Result and the final borrow to Bout, and the FSM goes to DONE.
  - DONE: done=1 for exactly this cycle. start=1 here is accepted exactly as in IDLE (back-to-back operation, next state RUN). Otherwise next state is IDLE.
- Status outputs: busy=1 in RUN only. done=1 in DONE only.
- Latency: start sampled at edge k produces done=1 in the cycle following edge k+WIDTH. Throughput is one result per WIDTH+1 cycles, back-to-back.
- start in RUN is ignored; operands in flight are not disturbed.
- Result and Bout change only on the transition into DONE, or on rst. They hold their last value otherwise, including during a following RUN.
- A and B may change freely after the accepting edge.
- rst asserted mid-RUN aborts the operation: no done pulse, outputs forced to reset values.
- Arithmetic:
  - Unsigned modulo 2^WIDTH.
  - A == B gives Result=0, Bout=0.
  - The borrow chain is never truncated: bit WIDTH-1 borrow is Bout.

Optional Feature:
- Macro: SERIAL_SUB_SIGNED_OVF_EN.
- When defined:
  - Extra output port Ovf (output, 1 bit), reset 0, updated together with Result on entry to DONE.
  - Ovf = 1 iff two's-complement signed overflow occurred: A[WIDTH-1] != B[WIDTH-1] and Result[WIDTH-1] != A[WIDTH-1].
  - The sign bits of A and B are captured at acceptance.
- When undefined: Ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release then A=5, B=3, start pulse -> busy high 4 cycles, done pulse in cycle after edge k+4, Result=2, Bout=0.
- A=3, B=5 -> Result=14 (0xE), Bout=1. A=0, B=1 -> Result=15, Bout=1. A=9, B=9 -> Result=0, Bout=0.
- Back-to-back: start held high through DONE with A=12, B=4 then A=1, B=2 -> done pulses 5 cycles apart, Result=8/Bout=0 then Result=15/Bout=1. start asserted during RUN with other operands -> ignored, result unchanged.
- rst asserted at 2nd RUN cycle of A=7, B=1 -> next cycle busy=0, done never pulses, Result=0, Bout=0. A fresh start then works normally.
- Operands changed every cycle after acceptance of A=10, B=6 -> Result=4 regardless.
- With SERIAL_SUB_SIGNED_OVF_EN:
  - A=8 (-8), B=1 -> Result=7, Ovf=1.
  - A=7, B=15 (-1) -> Result=8, Ovf=1.
  - A=2, B=3 -> Result=15, Ovf=0.
  - Exhaustive 4-bit sweep against a reference model, all outputs.
